uart_rx: RTL and testbench

Serial UART receiver: 8N1 framing by default (one start bit, DATA_LEN data bits LSB-first, one stop bit, no parity). It synchronises the asynchronous serial line, rejects start-bit glitches and samples every bit at mid-bit. Each good frame produces a parallel word with a one-cycle valid strobe; a bad stop bit produces a framing-error strobe instead. It is the receive-side counterpart of the bus UART transmitter and uses the same CLKS_PER_BIT convention, so a matched TX/RX pair shares one parameter value.

---
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop framing with a two-flop synchroniser.
// Every bit is sampled at mid-bit. Each good frame gives a one-cycle rx_valid; a bad stop bit gives frame_err.
module uart_rx #(
  parameter int unsigned DATA_LEN     = 8,
  parameter int unsigned CLKS_PER_BIT = 2604
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx_line,
  output logic [DATA_LEN-1:0] rx_word,
  output logic                rx_valid,
  output logic                rx_busy,
  output logic                frame_err
);

  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

  localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StFinish
  } state_e;

  state_e              state_q;
  logic [1:0]          sync_q;
  logic                rx_s;
  logic [CntW-1:0]     clk_count_q;
  logic [BitW-1:0]     bit_count_q;
  logic [DATA_LEN-1:0] shift_q;
  logic [DATA_LEN-1:0] rx_word_q;
  logic                rx_valid_q;
  logic                rx_busy_q;
  logic                frame_err_q;

  // Both stages reset high so that reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_line};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      clk_count_q <= '0;
      bit_count_q <= '0;
      shift_q     <= '0;
      rx_word_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q     <= StStart;
            clk_count_q <= '0;
            rx_busy_q   <= 1'b1;
          end
        end
        StStart: begin
          if (clk_count_q == HalfLast) begin
            clk_count_q <= '0;
            if (rx_s) begin
              // The line went high again before mid-start: treat it as a glitch.
              state_q   <= StIdle;
              rx_busy_q <= 1'b0;
            end else begin
              state_q     <= StData;
              bit_count_q <= '0;
            end
          end else begin
            clk_count_q <= clk_count_q + 1'b1;
          end
        end
        StData: begin
          if (clk_count_q == BitLast) begin
            clk_count_q          <= '0;
            shift_q[bit_count_q] <= rx_s;
            if (bit_count_q == DataLast) begin
              state_q <= StStop;
            end else begin
              bit_count_q <= bit_count_q + 1'b1;
            end
          end else begin
            clk_count_q <= clk_count_q + 1'b1;
          end
        end
        StStop: begin
          if (clk_count_q == BitLast) begin
            clk_count_q <= '0;
            state_q     <= StFinish;
            if (rx_s) begin
              rx_word_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            clk_count_q <= clk_count_q + 1'b1;
          end
        end
        StFinish: begin
          // Wait out a break or long low so it cannot retrigger a frame.
          if (rx_s) begin
            state_q   <= StIdle;
            rx_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_word   = rx_word_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;

  strobe_exclusive_a : assert property (@(posedge clk) disable iff (!reset_n)
    !(rx_valid && frame_err));
  valid_single_a : assert property (@(posedge clk) disable iff (!reset_n)
    rx_valid |=> !rx_valid);
  ferr_single_a : assert property (@(posedge clk) disable iff (!reset_n)
    frame_err |=> !frame_err);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a time-based reference model is compared every cycle.
// Directed frames are followed by randomised traffic.
module tb_uart_rx;

  localparam int Cpb  = 16;
  localparam int D    = 8;
  localparam int Half = Cpb / 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx_line = 1'b1;
  logic [D-1:0] rx_word;
  logic         rx_valid;
  logic         rx_busy;
  logic         frame_err;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_LEN    (D),
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_line  (rx_line),
    .rx_word  (rx_word),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tb_edges = 0;

  always @(posedge clk) tb_edges <= tb_edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, tb_edges);
    end
  endtask

  // Reference model: the line seen two edges late.
  // Samples are taken at absolute offsets from the edge where the start bit is first seen.
  logic         m_s1, m_s2;
  int           m_mode;  // 0 idle, 1 in frame, 2 waiting for line high
  int           m_t0;
  int           m_k;
  logic [D-1:0] m_data, m_word;
  logic         m_valid, m_ferr, m_busy;

  assign m_k = tb_edges - m_t0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= 1'b1; m_s2 <= 1'b1; m_mode <= 0; m_t0 <= 0;
      m_data <= '0; m_word <= '0; m_valid <= 1'b0; m_ferr <= 1'b0; m_busy <= 1'b0;
    end else begin
      m_s2    <= m_s1;
      m_s1    <= rx_line;
      m_valid <= 1'b0;
      m_ferr  <= 1'b0;
      case (m_mode)
        0: if (!m_s2) begin
          m_mode <= 1; m_t0 <= tb_edges; m_busy <= 1'b1;
        end
        1: begin
          if (m_k == Half) begin
            if (m_s2) begin m_mode <= 0; m_busy <= 1'b0; end
          end else if (m_k > Half && (m_k - Half) % Cpb == 0) begin
            if ((m_k - Half) / Cpb <= D) begin
              m_data[3'((m_k - Half) / Cpb - 1)] <= m_s2;
            end else begin
              m_mode <= 2;
              if (m_s2) begin m_word <= m_data; m_valid <= 1'b1; end
              else m_ferr <= 1'b1;
            end
          end
        end
        default: if (m_s2) begin m_mode <= 0; m_busy <= 1'b0; end
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("rx_word", 32'(rx_word), 32'(m_word));
    chk("rx_valid", 32'(rx_valid), 32'(m_valid));
    chk("rx_busy", 32'(rx_busy), 32'(m_busy));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
  end

  // Event monitor feeding the directed checks.
  int         n_valid = 0, n_ferr = 0;
  int         last_valid_edge = 0, busy_rise = 0, busy_fall = 0;
  logic       prev_busy = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      got_q.push_back(rx_word);
      last_valid_edge = tb_edges;
    end
    if (frame_err) n_ferr++;
    if (rx_busy && !prev_busy) busy_rise = tb_edges;
    if (!rx_busy && prev_busy) busy_fall = tb_edges;
    prev_busy = rx_busy;
  end

  task automatic drive_bit(input logic b, input int n);
    rx_line = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, Cpb);
    for (int i = 0; i < D; i++) drive_bit(b[i], Cpb);
    drive_bit(stop, Cpb);
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    if (got_q.size() > 0) chk(name, 32'(got_q.pop_front()), 32'(exp));
    else chk({name, "_present"}, 32'(got_q.size()), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         s, v0, f0;
    logic [7:0] lb[4];

    repeat (3) @(negedge clk);
    #1;
    chk("reset_word", 32'(rx_word), 32'd0);
    chk("reset_valid", 32'(rx_valid), 32'd0);
    chk("reset_busy", 32'(rx_busy), 32'd0);
    chk("reset_ferr", 32'(frame_err), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single good frame with exact strobe timing.
    got_q.delete();
    v0 = n_valid; f0 = n_ferr; s = tb_edges;
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1, Cpb);
    #1;
    chk("a5_count", 32'(n_valid - v0), 32'd1);
    chk("a5_edge", 32'(last_valid_edge), 32'(s + 3 + Half + (D + 1) * Cpb));
    chk("a5_busy_fall", 32'(busy_fall), 32'(last_valid_edge + 1));
    chk("a5_ferr", 32'(n_ferr - f0), 32'd0);
    pop_chk("a5_word", 8'hA5);

    // Back-to-back frames with no idle gap.
    v0 = n_valid;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive_bit(1'b1, Cpb);
    #1;
    chk("b2b_count", 32'(n_valid - v0), 32'd2);
    pop_chk("b2b_first", 8'h00);
    pop_chk("b2b_second", 8'hFF);
    chk("b2b_ferr", 32'(n_ferr - f0), 32'd0);

    // Glitch rejection.
    v0 = n_valid;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 3 * Cpb);
    #1;
    chk("glitch_valid", 32'(n_valid - v0), 32'd0);
    chk("glitch_ferr", 32'(n_ferr - f0), 32'd0);
    chk("glitch_busy_width", 32'(busy_fall - busy_rise), 32'(Half));
    chk("glitch_word", 32'(rx_word), 32'hFF);

    // Framing error followed by a long low.
    v0 = n_valid;
    send_frame(8'h3C, 1'b1);
    send_frame(8'h81, 1'b0);
    drive_bit(1'b0, 40);
    #1;
    chk("ferr_busy_low", 32'(rx_busy), 32'd1);
    drive_bit(1'b1, 3 * Cpb);
    #1;
    chk("ferr_count", 32'(n_ferr - f0), 32'd1);
    chk("ferr_valid", 32'(n_valid - v0), 32'd1);
    pop_chk("ferr_good_word", 8'h3C);
    chk("ferr_word_held", 32'(rx_word), 32'h3C);
    chk("ferr_busy_end", 32'(rx_busy), 32'd0);

    // Reset during data bit 3.
    drive_bit(1'b0, Cpb);
    for (int i = 0; i < 3; i++) drive_bit(1'(8'hC3 >> i), Cpb);
    drive_bit(1'b0, Half);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_word", 32'(rx_word), 32'd0);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    got_q.delete();
    v0 = n_valid;
    send_frame(8'h5A, 1'b1);
    drive_bit(1'b1, Cpb);
    #1;
    chk("rst_after_count", 32'(n_valid - v0), 32'd1);
    pop_chk("rst_after_word", 8'h5A);

    // Loopback-style byte stream.
    lb[0] = 8'h01; lb[1] = 8'h80; lb[2] = 8'h55; lb[3] = 8'hAA;
    v0 = n_valid;
    for (int i = 0; i < 4; i++) send_frame(lb[i], 1'b1);
    drive_bit(1'b1, Cpb);
    #1;
    chk("loop_count", 32'(n_valid - v0), 32'd4);
    for (int i = 0; i < 4; i++) pop_chk("loop_word", lb[i]);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 60; n++) begin
      int         r;
      logic [7:0] b;
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (r <= 5) begin
        send_frame(b, 1'b1);
        drive_bit(1'b1, int'($urandom_range(0, 3)));
      end else if (r == 6) begin
        send_frame(b, 1'b0);
        drive_bit(1'b1, int'($urandom_range(2, 20)));
      end else if (r == 7) begin
        drive_bit(1'b0, int'($urandom_range(1, 6)));
        drive_bit(1'b1, int'($urandom_range(Cpb, 2 * Cpb)));
      end else begin
        drive_bit(1'b1, int'($urandom_range(1, 3 * Cpb)));
      end
    end
    drive_bit(1'b1, 3 * Cpb);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
